// File: rtl/dpll_pkg.sv
// dpll_pkg: shared DPLL constants and the phase/period count type.
package dpll_pkg;
  localparam int N_BIT       = 12;
  localparam int GAIN_SHIFT  = 2;
  localparam int DEFAULT_PER = 16;
  localparam int MIN_PER     = 2;
  typedef logic [N_BIT-1:0] count_t;
endpackage

// File: rtl/freq_gen_div.sv
// freq_gen_div: period counter producing a ~50% duty f_out; new period loads only at wrap.
module freq_gen_div #(
  parameter int N_BIT       = 12,
  parameter int DEFAULT_PER = 16
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic [N_BIT-1:0] i_pend,
  output logic             o_f_out
);
  localparam logic [N_BIT-1:0] DEF_U = DEFAULT_PER[N_BIT-1:0];
  logic [N_BIT-1:0] r_cnt, r_per, w_half;
  logic             r_f_out, w_wrap;
  assign w_wrap = r_cnt == r_per - 1'b1;
  assign w_half = {1'b0, r_per[N_BIT-1:1]} + {{(N_BIT-1){1'b0}}, r_per[0]};
  // f_out is registered from the current count, so it trails the counter by one cycle
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_cnt   <= '0;
      r_per   <= DEF_U;
      r_f_out <= 1'b0;
    end else begin
      r_f_out <= r_cnt < w_half;
      r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) r_per <= i_pend;
    end
  end
  assign o_f_out = r_f_out;
endmodule

// File: rtl/freq_gen.sv
// freq_gen: DCO stage; turns phase error into a corrected period and drives the divider.
module freq_gen
  import dpll_pkg::*;
#(
  parameter int N_BIT       = dpll_pkg::N_BIT,
  parameter int GAIN_SHIFT  = dpll_pkg::GAIN_SHIFT,
  parameter int DEFAULT_PER = dpll_pkg::DEFAULT_PER,
  parameter int MIN_PER     = dpll_pkg::MIN_PER
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             ready,
  input  logic             first_second,
  input  logic             timeout,
  input  logic [N_BIT-1:0] diff_1,
  input  logic [N_BIT-1:0] diff_2,
  input  logic [N_BIT-1:0] f_in,
  output logic             f_out
);
  localparam logic [N_BIT-1:0]          MIN_U = MIN_PER[N_BIT-1:0];
  localparam logic [N_BIT-1:0]          DEF_U = DEFAULT_PER[N_BIT-1:0];
  localparam logic signed [N_BIT+1:0]   MIN_S = MIN_PER;
  localparam logic signed [N_BIT+1:0]   MAX_S = 2**N_BIT - 1;
  logic                    r_ready_q, w_upd;
  logic [N_BIT-1:0]        r_pend, w_clamp;
  logic signed [N_BIT:0]   w_e, w_corr;
  logic signed [N_BIT+1:0] w_corr_x, w_fin_x, w_p;
  assign w_upd    = ready & ~r_ready_q;
  assign w_e      = $signed({1'b0, diff_1}) - $signed({1'b0, diff_2});
  assign w_corr   = w_e >>> GAIN_SHIFT;
  assign w_corr_x = {w_corr[N_BIT], w_corr};
  assign w_fin_x  = $signed({2'b00, f_in});
  assign w_p      = first_second ? w_fin_x - w_corr_x : w_fin_x + w_corr_x;
  assign w_clamp  = w_p < MIN_S ? MIN_U : w_p > MAX_S ? '1 : w_p[N_BIT-1:0];
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_ready_q <= 1'b0;
      r_pend    <= DEF_U;
    end else begin
      r_ready_q <= ready;
      if (w_upd && !timeout && f_in >= MIN_U) r_pend <= w_clamp;
    end
  end
  freq_gen_div #(.N_BIT(N_BIT), .DEFAULT_PER(DEFAULT_PER)) u_div (
    .Clock  (Clock),
    .nReset (nReset),
    .i_pend (r_pend),
    .o_f_out(f_out)
  );
endmodule

// File: tb/tb_freq_gen.sv
// tb_freq_gen: table, hand-written and randomized checks of f_out high/low lengths.
`timescale 1ns/100ps
module tb_freq_gen;
  logic        Clock = 0, nReset = 0, ready = 0, first_second = 0, timeout = 0;
  logic [11:0] diff_1 = 0, diff_2 = 0, f_in = 0;
  logic        f_out;
  int          n_pass = 0, n_total = 0;
  int          cur_per = 16;

  freq_gen dut (
    .Clock(Clock), .nReset(nReset), .ready(ready), .first_second(first_second),
    .timeout(timeout), .diff_1(diff_1), .diff_2(diff_2), .f_in(f_in), .f_out(f_out)
  );

  always #0.5 Clock = ~Clock;

  typedef struct {
    int d1, d2, fin, fs, to, exp_p;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic wait_rise(input string name);
    int  n = 0;
    bit  ok = 0;
    logic prev = f_out;
    while (n < 10000 && !ok) begin
      @(negedge Clock);
      n++;
      ok = !prev && f_out;
      prev = f_out;
    end
    check({name, "_rise_seen"}, int'(ok), 1);
  endtask

  task automatic measure(output int hi, output int lo);
    hi = 0;
    lo = 0;
    while (f_out && hi < 10000) begin hi++; @(negedge Clock); end
    while (!f_out && lo < 10000) begin lo++; @(negedge Clock); end
  endtask

  task automatic apply(input int d1, input int d2, input int fin, input int fs, input int to);
    @(negedge Clock);
    diff_1 = 12'(d1); diff_2 = 12'(d2); f_in = 12'(fin);
    first_second = fs[0]; timeout = to[0]; ready = 1;
    @(negedge Clock);
    ready = 0;
  endtask

  task automatic settle_check(input string name, input int p);
    int hi, lo;
    wait_rise(name);
    wait_rise(name);
    measure(hi, lo);
    check({name, "_hi"}, hi, (p + 1) / 2);
    check({name, "_lo"}, lo, p / 2);
  endtask

  // Reference: floor-divided phase error by the loop gain, then saturate to the legal range
  function automatic int model(input int d1, input int d2, input int fin, input int fs, input int cur);
    int e, c, p;
    if (fin < 2) return cur;
    e = d1 - d2;
    c = e >= 0 ? e / 4 : -((-e + 3) / 4);
    p = fs != 0 ? fin - c : fin + c;
    return p < 2 ? 2 : p > 4095 ? 4095 : p;
  endfunction

  initial begin
    vec_t tbl[10];
    int   hi, lo;
    tbl = '{
      '{650, 400, 30, 0, 0, 92},
      '{20, 25, 30, 0, 0, 28},
      '{20, 25, 30, 1, 0, 32},
      '{0, 1, 100, 0, 0, 99},
      '{0, 4095, 2, 0, 0, 2},
      '{4095, 0, 4095, 0, 0, 4095},
      '{0, 0, 40, 0, 0, 40},
      '{0, 0, 50, 0, 1, 40},
      '{0, 0, 1, 0, 0, 40},
      '{8, 0, 20, 1, 0, 18}
    };
    #3.2;
    check("reset_fout", int'(f_out), 0);
    @(negedge Clock);
    nReset = 1;
    settle_check("reset_default", 16);

    foreach (tbl[i]) begin
      apply(tbl[i].d1, tbl[i].d2, tbl[i].fin, tbl[i].fs, tbl[i].to);
      settle_check($sformatf("tbl%0d", i), tbl[i].exp_p);
      timeout = 0;
    end

    // period 500, then a new period 4 arriving mid-high must not disturb the running cycle
    apply(0, 0, 500, 0, 0);
    settle_check("p500", 500);
    wait_rise("p500_sync");
    diff_1 = 0; diff_2 = 0; f_in = 4; first_second = 0; ready = 1;
    @(negedge Clock);
    ready = 0;
    measure(hi, lo);
    check("wrap_keep_hi", hi + 1, 250);
    check("wrap_keep_lo", lo, 250);
    measure(hi, lo);
    check("wrap_new_hi", hi, 2);
    check("wrap_new_lo", lo, 2);
    cur_per = 4;

    for (int k = 0; k < 8; k++) begin
      int d1, d2, fin, fs;
      d1  = int'($urandom_range(0, 300));
      d2  = int'($urandom_range(0, 300));
      fin = int'($urandom_range(0, 150));
      fs  = int'($urandom_range(0, 1));
      cur_per = model(d1, d2, fin, fs, cur_per);
      apply(d1, d2, fin, fs, 0);
      settle_check($sformatf("rnd%0d", k), cur_per);
    end

    wait_rise("midrst");
    @(negedge Clock);
    #0.2 nReset = 0;
    #0.1 check("midrst_fout_now", int'(f_out), 0);
    @(negedge Clock);
    @(negedge Clock);
    check("midrst_fout_held", int'(f_out), 0);
    nReset = 1;
    settle_check("midrst_default", 16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
